// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus between two writeback sources, the register file pins and read consumers.
// The slave modport is the arbiter side; the master modport is the environment side.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wr0_valid;
  logic              wr0_ready;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_valid;
  logic              wr1_ready;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rf_rd_data1;
  logic [DATA_W-1:0] rf_rd_data2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              busy;

  modport slave (
    input  wr0_valid, wr0_addr, wr0_data,
    input  wr1_valid, wr1_addr, wr1_data,
    input  rd_addr1, rd_addr2, rf_rd_data1, rf_rd_data2,
    output wr0_ready, wr1_ready,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    output rd_data1, rd_data2, busy
  );

  modport master (
    output wr0_valid, wr0_addr, wr0_data,
    output wr1_valid, wr1_addr, wr1_data,
    output rd_addr1, rd_addr2, rf_rd_data1, rf_rd_data2,
    input  wr0_ready, wr1_ready,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    input  rd_data1, rd_data2, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-channel writeback arbiter with 1-entry buffers, oldest-first drain into one RF write port.
// Define REGFILE_BYPASS_EN to forward pending buffered data to the read ports.
module regfile_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wr_arbiter_if.slave  bus
);

  logic              full0_q, full0_d;
  logic              full1_q, full1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              old_sel_q, old_sel_d;

  logic grant0, grant1;
  logic ready0, ready1;
  logic acc0, acc1;

  always_comb begin
    grant0 = full0_q & (~full1_q | ~old_sel_q);
    grant1 = full1_q & (~full0_q |  old_sel_q);
    ready0 = ~full0_q | grant0;
    ready1 = ~full1_q | grant1;
    acc0   = bus.wr0_valid & ready0;
    acc1   = bus.wr1_valid & ready1;
  end

  assign bus.wr0_ready = ready0;
  assign bus.wr1_ready = ready1;

  // A buffer loaded this edge is younger than one that stayed; simultaneous loads leave ch0 older.
  always_comb begin
    full0_d   = (full0_q & ~grant0) | acc0;
    full1_d   = (full1_q & ~grant1) | acc1;
    addr0_d   = acc0 ? bus.wr0_addr : addr0_q;
    data0_d   = acc0 ? bus.wr0_data : data0_q;
    addr1_d   = acc1 ? bus.wr1_addr : addr1_q;
    data1_d   = acc1 ? bus.wr1_data : data1_q;
    old_sel_d = old_sel_q;
    if (acc0 & acc1) begin
      old_sel_d = 1'b0;
    end else if (acc0) begin
      old_sel_d = 1'b1;
    end else if (acc1) begin
      old_sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full0_q   <= 1'b0;
      full1_q   <= 1'b0;
      addr0_q   <= '0;
      addr1_q   <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      old_sel_q <= 1'b0;
    end else begin
      full0_q   <= full0_d;
      full1_q   <= full1_d;
      addr0_q   <= addr0_d;
      addr1_q   <= addr1_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      old_sel_q <= old_sel_d;
    end
  end

  always_comb begin
    bus.rf_wr_en   = full0_q | full1_q;
    bus.busy       = full0_q | full1_q;
    bus.rf_wr_addr = '0;
    bus.rf_wr_data = '0;
    if (grant0) begin
      bus.rf_wr_addr = addr0_q;
      bus.rf_wr_data = data0_q;
    end else if (grant1) begin
      bus.rf_wr_addr = addr1_q;
      bus.rf_wr_data = data1_q;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // With both buffers matching, the younger one (not selected by old_sel) holds the newest value.
  function automatic logic [DATA_W-1:0] bypass(input logic [ADDR_W-1:0] ra,
                                               input logic [DATA_W-1:0] rf_data);
    logic m0, m1;
    m0 = full0_q & (addr0_q == ra);
    m1 = full1_q & (addr1_q == ra);
    if (m0 & m1) begin
      return old_sel_q ? data0_q : data1_q;
    end else if (m0) begin
      return data0_q;
    end else if (m1) begin
      return data1_q;
    end
    return rf_data;
  endfunction

  always_comb begin
    bus.rd_data1 = bypass(bus.rd_addr1, bus.rf_rd_data1);
    bus.rd_data2 = bypass(bus.rd_addr2, bus.rf_rd_data2);
  end
`else
  always_comb begin
    bus.rd_data1 = bus.rf_rd_data1;
    bus.rd_data2 = bus.rf_rd_data2;
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural 8x16 register file on the write port.
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_wr_arbiter_if #(.DATA_W(16), .ADDR_W(3)) ifc ();

  regfile_wr_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  logic [15:0] mem [8] = '{default: '0};

  always @(posedge clk) begin
    if (ifc.rf_wr_en) mem[ifc.rf_wr_addr] <= ifc.rf_wr_data;
  end

  assign ifc.rf_rd_data1 = mem[ifc.rd_addr1];
  assign ifc.rf_rd_data2 = mem[ifc.rd_addr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ifc.wr0_valid = 1'b0; ifc.wr0_addr = '0; ifc.wr0_data = '0;
    ifc.wr1_valid = 1'b0; ifc.wr1_addr = '0; ifc.wr1_data = '0;
    ifc.rd_addr1 = '0; ifc.rd_addr2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (ifc.rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", ifc.rf_wr_en); end
    checks++; if (ifc.rf_wr_addr !== 3'd0) begin errors++; $display("FAIL reset_wr_addr got=%h exp=0", ifc.rf_wr_addr); end
    checks++; if (ifc.rf_wr_data !== 16'h0000) begin errors++; $display("FAIL reset_wr_data got=%h exp=0000", ifc.rf_wr_data); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    checks++; if ({ifc.wr0_ready, ifc.wr1_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got=%b exp=11", {ifc.wr0_ready, ifc.wr1_ready}); end
  endtask

  task automatic test_single_write;
    ifc.wr0_valid = 1'b1; ifc.wr0_addr = 3'd3; ifc.wr0_data = 16'hF000;
    checks++; if (ifc.wr0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", ifc.wr0_ready); end
    tick();
    ifc.wr0_valid = 1'b0;
    checks++; if ({ifc.rf_wr_en, ifc.rf_wr_addr, ifc.rf_wr_data} !== {1'b1, 3'd3, 16'hF000})
      begin errors++; $display("FAIL single_wr got=%b/%h/%h exp=1/3/f000", ifc.rf_wr_en, ifc.rf_wr_addr, ifc.rf_wr_data); end
    checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", ifc.busy); end
    tick();
    ifc.rd_addr1 = 3'd3;
    #1;
    checks++; if (ifc.rd_data1 !== 16'hF000) begin errors++; $display("FAIL single_read got=%h exp=f000", ifc.rd_data1); end
    checks++; if (ifc.rf_wr_en !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", ifc.rf_wr_en); end
  endtask

  task automatic test_both_same_cycle;
    ifc.wr0_valid = 1'b1; ifc.wr0_addr = 3'd2; ifc.wr0_data = 16'h0F00;
    ifc.wr1_valid = 1'b1; ifc.wr1_addr = 3'd5; ifc.wr1_data = 16'h00AA;
    tick();
    ifc.wr0_valid = 1'b0; ifc.wr1_valid = 1'b0;
    checks++; if ({ifc.rf_wr_addr, ifc.rf_wr_data} !== {3'd2, 16'h0F00})
      begin errors++; $display("FAIL both_first got=%h/%h exp=2/0f00", ifc.rf_wr_addr, ifc.rf_wr_data); end
    checks++; if ({ifc.wr0_ready, ifc.wr1_ready} !== 2'b10)
      begin errors++; $display("FAIL both_ready1 got=%b exp=10", {ifc.wr0_ready, ifc.wr1_ready}); end
    tick();
    checks++; if ({ifc.rf_wr_en, ifc.rf_wr_addr, ifc.rf_wr_data} !== {1'b1, 3'd5, 16'h00AA})
      begin errors++; $display("FAIL both_second got=%b/%h/%h exp=1/5/00aa", ifc.rf_wr_en, ifc.rf_wr_addr, ifc.rf_wr_data); end
    checks++; if (ifc.wr1_ready !== 1'b1) begin errors++; $display("FAIL both_ready2 got=%b exp=1", ifc.wr1_ready); end
    tick();
    ifc.rd_addr1 = 3'd2; ifc.rd_addr2 = 3'd5;
    #1;
    checks++; if ({ifc.rd_data1, ifc.rd_data2} !== {16'h0F00, 16'h00AA})
      begin errors++; $display("FAIL both_read got=%h/%h exp=0f00/00aa", ifc.rd_data1, ifc.rd_data2); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ea [8];
    logic [15:0] ed [8];
    int unsigned i0, i1;
    logic f0, f1;
    for (int k = 0; k < 8; k++) begin
      ea[k] = (k % 2 == 0) ? 3'(k / 2) : 3'(4 + k / 2);
      ed[k] = (k % 2 == 0) ? 16'hA000 + 16'(k / 2) : 16'hB000 + 16'(k / 2);
    end
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      ifc.wr0_valid = (i0 < 4); ifc.wr0_addr = 3'(i0);     ifc.wr0_data = 16'hA000 + 16'(i0);
      ifc.wr1_valid = (i1 < 4); ifc.wr1_addr = 3'(4 + i1); ifc.wr1_data = 16'hB000 + 16'(i1);
      f0 = ifc.wr0_valid & ifc.wr0_ready;
      f1 = ifc.wr1_valid & ifc.wr1_ready;
      tick();
      if (f0) i0++;
      if (f1) i1++;
      checks++; if ({ifc.rf_wr_en, ifc.busy, ifc.rf_wr_addr, ifc.rf_wr_data} !== {2'b11, ea[k], ed[k]})
        begin errors++; $display("FAIL b2b_cycle%0d got=%b%b/%h/%h exp=11/%h/%h", k, ifc.rf_wr_en, ifc.busy,
                                 ifc.rf_wr_addr, ifc.rf_wr_data, ea[k], ed[k]); end
    end
    ifc.wr0_valid = 1'b0; ifc.wr1_valid = 1'b0;
    checks++; if (i0 != 4 || i1 != 4) begin errors++; $display("FAIL b2b_accepts got=%0d/%0d exp=4/4", i0, i1); end
    tick();
    checks++; if ({ifc.rf_wr_en, ifc.busy} !== 2'b00) begin errors++; $display("FAIL b2b_drain got=%b%b exp=00", ifc.rf_wr_en, ifc.busy); end
    for (int r = 0; r < 8; r++) begin
      ifc.rd_addr1 = 3'(r);
      #1;
      checks++; if (ifc.rd_data1 !== ((r < 4) ? 16'hA000 + 16'(r) : 16'hB000 + 16'(r - 4)))
        begin errors++; $display("FAIL b2b_reg%0d got=%h", r, ifc.rd_data1); end
    end
  endtask

  task automatic test_same_addr;
    ifc.rd_addr2 = 3'd4;
    ifc.wr1_valid = 1'b1; ifc.wr1_addr = 3'd4; ifc.wr1_data = 16'h1111;
    tick();
    ifc.wr1_valid = 1'b0;
    ifc.wr0_valid = 1'b1; ifc.wr0_addr = 3'd4; ifc.wr0_data = 16'h2222;
`ifdef REGFILE_BYPASS_EN
    checks++; if (ifc.rd_data2 !== 16'h1111) begin errors++; $display("FAIL waw_byp1 got=%h exp=1111", ifc.rd_data2); end
`else
    checks++; if (ifc.rd_data2 !== 16'hB000) begin errors++; $display("FAIL waw_pass1 got=%h exp=b000", ifc.rd_data2); end
`endif
    tick();
    ifc.wr0_valid = 1'b0;
`ifdef REGFILE_BYPASS_EN
    checks++; if (ifc.rd_data2 !== 16'h2222) begin errors++; $display("FAIL waw_byp2 got=%h exp=2222", ifc.rd_data2); end
`else
    checks++; if (ifc.rd_data2 !== 16'h1111) begin errors++; $display("FAIL waw_pass2 got=%h exp=1111", ifc.rd_data2); end
`endif
    checks++; if ({ifc.rf_wr_addr, ifc.rf_wr_data} !== {3'd4, 16'h2222})
      begin errors++; $display("FAIL waw_wr got=%h/%h exp=4/2222", ifc.rf_wr_addr, ifc.rf_wr_data); end
    tick();
    checks++; if (ifc.rd_data2 !== 16'h2222) begin errors++; $display("FAIL waw_final got=%h exp=2222", ifc.rd_data2); end

    ifc.rd_addr1 = 3'd6;
    ifc.wr0_valid = 1'b1; ifc.wr0_addr = 3'd6; ifc.wr0_data = 16'h6060;
    ifc.wr1_valid = 1'b1; ifc.wr1_addr = 3'd6; ifc.wr1_data = 16'h6161;
    tick();
    ifc.wr0_valid = 1'b0; ifc.wr1_valid = 1'b0;
`ifdef REGFILE_BYPASS_EN
    checks++; if (ifc.rd_data1 !== 16'h6161) begin errors++; $display("FAIL waw6_byp got=%h exp=6161", ifc.rd_data1); end
`else
    checks++; if (ifc.rd_data1 !== 16'hB002) begin errors++; $display("FAIL waw6_pass got=%h exp=b002", ifc.rd_data1); end
`endif
    tick();
`ifdef REGFILE_BYPASS_EN
    checks++; if (ifc.rd_data1 !== 16'h6161) begin errors++; $display("FAIL waw6_byp2 got=%h exp=6161", ifc.rd_data1); end
`else
    checks++; if (ifc.rd_data1 !== 16'h6060) begin errors++; $display("FAIL waw6_pass2 got=%h exp=6060", ifc.rd_data1); end
`endif
    tick();
    checks++; if (ifc.rd_data1 !== 16'h6161) begin errors++; $display("FAIL waw6_final got=%h exp=6161", ifc.rd_data1); end
  endtask

  task automatic test_reset_midcycle;
    ifc.wr0_valid = 1'b1; ifc.wr0_addr = 3'd1; ifc.wr0_data = 16'hDEAD;
    ifc.wr1_valid = 1'b1; ifc.wr1_addr = 3'd7; ifc.wr1_data = 16'hBEEF;
    tick();
    ifc.wr0_valid = 1'b0; ifc.wr1_valid = 1'b0;
    checks++; if ({ifc.busy, ifc.rf_wr_en} !== 2'b11) begin errors++; $display("FAIL rst_prefull got=%b%b exp=11", ifc.busy, ifc.rf_wr_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({ifc.rf_wr_en, ifc.busy, ifc.wr0_ready, ifc.wr1_ready} !== 4'b0011)
      begin errors++; $display("FAIL rst_async got=%b%b%b%b exp=0011", ifc.rf_wr_en, ifc.busy, ifc.wr0_ready, ifc.wr1_ready); end
    checks++; if ({ifc.rf_wr_addr, ifc.rf_wr_data} !== 19'd0)
      begin errors++; $display("FAIL rst_bus got=%h/%h exp=0/0000", ifc.rf_wr_addr, ifc.rf_wr_data); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ifc.rd_addr1 = 3'd1; ifc.rd_addr2 = 3'd7;
    #1;
    checks++; if ({ifc.rd_data1, ifc.rd_data2} !== {16'hA001, 16'hB003})
      begin errors++; $display("FAIL rst_keep got=%h/%h exp=a001/b003", ifc.rd_data1, ifc.rd_data2); end
    checks++; if ({ifc.busy, ifc.wr0_ready, ifc.wr1_ready} !== 3'b011)
      begin errors++; $display("FAIL rst_after got=%b%b%b exp=011", ifc.busy, ifc.wr0_ready, ifc.wr1_ready); end
  endtask

  task automatic test_idle;
    logic [15:0] regs [8];
    regs = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'h2222, 16'hB001, 16'h6161, 16'hB003};
    for (int c = 0; c < 5; c++) begin
      tick();
      ifc.rd_addr1 = 3'(c);
      ifc.rd_addr2 = 3'(7 - c);
      #1;
      checks++; if ({ifc.rf_wr_en, ifc.rf_wr_addr, ifc.rf_wr_data} !== 20'd0)
        begin errors++; $display("FAIL idle_wr%0d got=%b/%h/%h exp=0/0/0000", c, ifc.rf_wr_en, ifc.rf_wr_addr, ifc.rf_wr_data); end
      checks++; if ({ifc.rd_data1, ifc.rd_data2} !== {regs[c], regs[7 - c]})
        begin errors++; $display("FAIL idle_rd%0d got=%h/%h exp=%h/%h", c, ifc.rd_data1, ifc.rd_data2, regs[c], regs[7 - c]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_write();
    test_both_same_cycle();
    test_back_to_back();
    test_same_addr();
    test_reset_midcycle();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
